// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, addresses the instruction ROM and queues {pc, instr}
// pairs for decode. Redirects flush the queue; a misaligned target halts fetch.
module instruction_fetch #(
  parameter int          ROM_SIZE = 64,
  parameter int          ADDR_W   = $clog2(ROM_SIZE),
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              fault
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0]      NOP  = 32'h0000_0013;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

  logic [31:0]      pc;
  logic [31:0]      q_pc    [QDEPTH];
  logic [31:0]      q_instr [QDEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;

  assign imem_addr = pc[ADDR_W+1:2];
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? q_instr[rd_ptr] : NOP;
  assign out_pc    = out_valid ? q_pc[rd_ptr]    : 32'h0;

  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = !fault & !redirect_valid & ((count < FULL) | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fault  <= 1'b0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (redirect_pc[1:0] != 2'b00) begin
        fault <= 1'b1;
        pc    <= {redirect_pc[31:2], 2'b00};
      end else begin
        pc <= redirect_pc;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        pc     <= pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries no reset; count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_instruction_fetch;

  localparam int          ROM_N = 64;
  localparam int          AW    = 6;
  localparam int          QD    = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          fault;

  logic [31:0] rom [ROM_N];
  assign imem_data = rom[imem_addr];

  instruction_fetch #(
    .ROM_SIZE(ROM_N),
    .ADDR_W  (AW),
    .RESET_PC(RPC),
    .QDEPTH  (QD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the fetch queue as a list of {pc, instr} pairs.
  logic [63:0] mq [$];
  logic [31:0] m_pc;
  logic        m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    ev  = (mq.size() > 0);
    epc = ev ? mq[0][63:32] : 32'h0;
    ein = ev ? mq[0][31:0]  : NOP;
    chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
    chk("out_pc", out_pc, epc);
    chk("out_instr", out_instr, ein);
    chk("imem_addr", {26'b0, imem_addr}, {26'b0, m_pc[AW+1:2]});
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
  endtask

  task automatic model_edge(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    if (r) begin
      mq.delete();
      m_pc    = RPC;
      m_fault = 1'b0;
    end else begin
      bit pop_m  = (mq.size() > 0) && rdy;
      bit push_m = !m_fault && !rv && ((mq.size() < QD) || pop_m);
      if (rv) begin
        mq.delete();
        if (rpc[1:0] != 2'b00) begin
          m_fault = 1'b1;
          m_pc    = rpc - {30'b0, rpc[1:0]};
        end else begin
          m_pc = rpc;
        end
      end else begin
        if (pop_m) void'(mq.pop_front());
        if (push_m) begin
          mq.push_back({m_pc, rom[m_pc[AW+1:2]]});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge(r, rv, rpc, rdy);
    #1;
  endtask

  initial begin
    for (int i = 0; i < ROM_N; i++) rom[i] = 32'h1000_0000 + i;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_edge(1'b1, 1'b0, 32'h0, 1'b1);

    // Reset state and streaming
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Backpressure right after reset
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("bp_imem_addr", {26'b0, imem_addr}, 32'd2);
    chk("bp_head_pc", out_pc, 32'h0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect on a full queue
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h40, 1'b0);
    chk("rd_valid_low", {31'b0, out_valid}, 32'h0);
    chk("rd_imem_addr", {26'b0, imem_addr}, 32'd16);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_target_pc", out_pc, 32'h40);
    chk("rd_target_instr", out_instr, 32'h1000_0010);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect together with a pop of head pc 0x8
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rp_head_pc", out_pc, 32'h8);
    cycle(1'b0, 1'b1, 32'h80, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Misaligned redirect, fault holds, reset recovers
    cycle(1'b0, 1'b1, 32'h22, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mis_fault", {31'b0, fault}, 32'h1);
    chk("mis_imem_addr", {26'b0, imem_addr}, 32'd8);
    cycle(1'b0, 1'b1, 32'h40, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Wrap-around and ROM aliasing
    cycle(1'b0, 1'b1, 32'h0000_00FC, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic with random ROM contents
    for (int i = 0; i < ROM_N; i++) rom[i] = $urandom;
    for (int n = 0; n < 3000; n++) begin
      logic        r, rv, rdy;
      logic [31:0] t;
      r   = ($urandom_range(99) == 0);
      rv  = ($urandom_range(9) == 0);
      rdy = ($urandom_range(9) < 7);
      case ($urandom_range(15))
        0:       t = $urandom;
        1:       t = {24'b0, 6'($urandom), 2'($urandom)};
        2:       t = 32'hFFFF_FFF0 + {28'b0, 2'($urandom), 2'b00};
        default: t = {22'b0, 8'($urandom), 2'b00};
      endcase
      if (n % 500 == 250) rom[$urandom_range(ROM_N - 1)] = $urandom;
      cycle(r, rv, t, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
